frame_write_sequencer: RTL

Parametrised framebuffer write sequencer. It runs NUM_CH painter channels (character typer, trajectory drawer, future sprite/overlay painters) in fixed order, issuing ch_len[c] start/finish jobs per channel. It muxes the active channel's write port onto the single 19-bit-address pixel-index memory port. It supersedes the hard-wired two-phase typer/draw writer with per-channel lengths, zero-length skip, colour override, abort, and one-shot or continuous frames.

---
 rtl/frame_write_sequencer_pkg.sv | 33 +++
 rtl/frame_write_sequencer_if.sv | 25 ++
 rtl/frame_write_sequencer_port_mux.sv | 49 ++++
 rtl/frame_write_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/frame_write_sequencer_pkg.sv
// Shared types and helpers for the frame write sequencer: FSM state encoding,
// default bus widths and a flattened-bus slice extractor.
package frame_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_LAUNCH  = 3'd2,
      S_WAIT    = 3'd3,
      S_ADVANCE = 3'd4,
      S_DONE    = 3'd5
   } seq_state_t;

   localparam int unsigned DEF_ADDR_W = 19;
   localparam int unsigned DEF_DATA_W = 3;
   localparam int unsigned DEF_CNT_W  = 16;

   // Flattened buses are zero-padded to BUS_MAX before slicing; slices up to SLICE_MAX wide.
   localparam int unsigned BUS_MAX   = 256;
   localparam int unsigned SLICE_MAX = 32;

   function automatic logic [SLICE_MAX-1:0] slice_of(input logic [BUS_MAX-1:0] flat,
                                                     input int unsigned        w,
                                                     input int unsigned        c);
      logic [SLICE_MAX-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < SLICE_MAX; i++) begin
         if (i < w && (w * c + i) < BUS_MAX) r[i] = flat[w * c + i];
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_write_sequencer_if.sv
// Painter-channel handshake/write bus plus the single framebuffer write port.
interface frame_write_sequencer_if import frame_seq_pkg::*; #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic [NUM_CH-1:0]        ch_start;
   logic [NUM_CH-1:0]        ch_finish;
   logic [NUM_CH*ADDR_W-1:0] ch_waddr;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [NUM_CH-1:0]        ch_wenable;
   logic [ADDR_W-1:0]        mem_waddr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_wenable;

   modport master (
      output ch_start, mem_waddr, mem_wdata, mem_wenable,
      input  ch_finish, ch_waddr, ch_wdata, ch_wenable
   );

   modport slave (
      input  ch_start, mem_waddr, mem_wdata, mem_wenable,
      output ch_finish, ch_waddr, ch_wdata, ch_wenable
   );
endinterface

// File: rtl/frame_write_sequencer_port_mux.sv
// Registered NUM_CH-to-1 framebuffer write mux with per-channel colour override;
// the write enable is gated so only the sequenced job's WAIT phase reaches memory.
module fsw_port_mux import frame_seq_pkg::*; #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CH_W   = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CH_W-1:0]          sel,
   input  logic                     write_gate,
   input  logic [NUM_CH*ADDR_W-1:0] ch_waddr,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   input  logic [NUM_CH-1:0]        ch_wenable,
   input  logic [NUM_CH-1:0]        ch_ovr_en,
   input  logic [NUM_CH*DATA_W-1:0] ch_ovr_data,
   output logic [ADDR_W-1:0]        mem_waddr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_wenable
);
   logic [NUM_CH-1:0] sel_onehot;
   logic [ADDR_W-1:0] waddr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic [DATA_W-1:0] ovr_sel;
   logic              wen_sel;
   logic              ovr_en_sel;

   always_comb begin
      sel_onehot = NUM_CH'(1) << sel;
      waddr_sel  = ADDR_W'(slice_of(BUS_MAX'(ch_waddr), ADDR_W, 32'(sel)));
      wdata_sel  = DATA_W'(slice_of(BUS_MAX'(ch_wdata), DATA_W, 32'(sel)));
      ovr_sel    = DATA_W'(slice_of(BUS_MAX'(ch_ovr_data), DATA_W, 32'(sel)));
      wen_sel    = |(ch_wenable & sel_onehot);
      ovr_en_sel = |(ch_ovr_en & sel_onehot);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_waddr   <= '0;
         mem_wdata   <= '0;
         mem_wenable <= 1'b0;
      end else begin
         mem_waddr   <= waddr_sel;
         mem_wdata   <= ovr_en_sel ? ovr_sel : wdata_sel;
         mem_wenable <= wen_sel && write_gate;
      end
   end
endmodule

// File: rtl/frame_write_sequencer.sv
// Framebuffer write sequencer: runs NUM_CH painter channels in order, issuing
// ch_len[c] start/finish jobs each, and muxes the active channel onto memory.
module frame_write_sequencer import frame_seq_pkg::*; #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned CH_W   = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     continuous,
   input  logic [NUM_CH*CNT_W-1:0]  ch_len,
   input  logic [NUM_CH-1:0]        ch_ovr_en,
   input  logic [NUM_CH*DATA_W-1:0] ch_ovr_data,
   output logic [CH_W-1:0]          active_ch,
   output logic [CNT_W-1:0]         item_index,
   output logic                     busy,
   output logic                     frame_done,
   frame_write_sequencer_if.master  bus
);
   seq_state_t              state;
   logic [NUM_CH*CNT_W-1:0] len_q;
   logic [CNT_W-1:0]        cur_len;
   logic                    fin_sel;
   logic                    last_ch;
   logic                    last_item;

   always_comb begin
      cur_len   = CNT_W'(slice_of(BUS_MAX'(len_q), CNT_W, 32'(active_ch)));
      fin_sel   = |(bus.ch_finish & (NUM_CH'(1) << active_ch));
      last_ch   = (active_ch == CH_W'(NUM_CH - 1));
      last_item = (item_index == cur_len - CNT_W'(1));
   end

   // Outputs are registered alongside the state, so each is set on entry to the state it marks.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         active_ch    <= '0;
         item_index   <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         bus.ch_start <= '0;
      end else begin
         bus.ch_start <= '0;
         frame_done   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (enable) begin
                  len_q      <= ch_len;
                  active_ch  <= '0;
                  item_index <= '0;
                  busy       <= 1'b1;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cur_len == '0) begin
                  if (last_ch) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     active_ch <= active_ch + CH_W'(1);
                  end
               end else begin
                  bus.ch_start <= NUM_CH'(1) << active_ch;
                  state        <= S_LAUNCH;
               end
            end
            S_LAUNCH: state <= S_WAIT;
            S_WAIT: begin
               if (fin_sel) state <= S_ADVANCE;
            end
            S_ADVANCE: begin
               if (last_item) begin
                  item_index <= '0;
                  if (last_ch) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     active_ch <= active_ch + CH_W'(1);
                     state     <= S_SETUP;
                  end
               end else begin
                  item_index <= item_index + CNT_W'(1);
                  if (enable) begin
                     bus.ch_start <= NUM_CH'(1) << active_ch;
                     state        <= S_LAUNCH;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               if (continuous && enable) begin
                  len_q      <= ch_len;
                  active_ch  <= '0;
                  item_index <= '0;
                  state      <= S_SETUP;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   fsw_port_mux #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CH_W   (CH_W)
   ) u_port_mux (
      .clock       (clock),
      .reset       (reset),
      .sel         (active_ch),
      .write_gate  (state == S_WAIT),
      .ch_waddr    (bus.ch_waddr),
      .ch_wdata    (bus.ch_wdata),
      .ch_wenable  (bus.ch_wenable),
      .ch_ovr_en   (ch_ovr_en),
      .ch_ovr_data (ch_ovr_data),
      .mem_waddr   (bus.mem_waddr),
      .mem_wdata   (bus.mem_wdata),
      .mem_wenable (bus.mem_wenable)
   );
endmodule
